// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester flash read arbiter.
package flash_arb_pkg;

   localparam int ADDR_W           = 24;
   localparam int DEF_TIMEOUT      = 255;
   localparam int DEF_FLUSH_CYCLES = 64;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef enum logic [2:0] {
      ST_FLUSH   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DELIVER = 3'd4
   } state_t;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester handshakes plus the flash reader bus, seen from the arbiter (slave)
// and from the clients/reader (master).
interface flash_read_arbiter_if #(parameter int LEN_W = 8);
   import flash_arb_pkg::*;

   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic [LEN_W-1:0]  a_len;
   logic              a_busy;
   logic              a_valid;
   logic              a_ack;
   logic              a_done;
   logic              a_err;

   logic              b_req;
   logic [ADDR_W-1:0] b_addr;
   logic [LEN_W-1:0]  b_len;
   logic              b_busy;
   logic              b_valid;
   logic              b_ack;
   logic              b_done;
   logic              b_err;

   logic [7:0]        rd_data;

   logic              fl_read;
   logic [ADDR_W-1:0] fl_addr;
   logic              fl_ready;
   logic [7:0]        fl_data;

   modport slave (
      input  a_req, a_addr, a_len, a_ack,
      input  b_req, b_addr, b_len, b_ack,
      input  fl_ready, fl_data,
      output a_busy, a_valid, a_done, a_err,
      output b_busy, b_valid, b_done, b_err,
      output rd_data, fl_read, fl_addr
   );

   modport master (
      output a_req, a_addr, a_len, a_ack,
      output b_req, b_addr, b_len, b_ack,
      output fl_ready, fl_data,
      input  a_busy, a_valid, a_done, a_err,
      input  b_busy, b_valid, b_done, b_err,
      input  rd_data, fl_read, fl_addr
   );

endinterface

// File: rtl/flash_arb_rr2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module flash_arb_rr2
   import flash_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   // One-hot grant, suppressed while the arbiter cannot accept a new burst.
   always_comb begin
      o_grant = 2'b00;
      if (i_enable) begin
         if (i_req == 2'b11) begin
            o_grant = (i_last_grant == REQ_A) ? 2'b10 : 2'b01;
         end else begin
            o_grant = i_req;
         end
      end
   end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one single-byte flash reader between requesters A and B. A granted
// burst is served as one read per byte with an incrementing address; each
// byte is handed back through a valid/ack handshake.
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int LEN_W        = 8,
   parameter int TIMEOUT      = DEF_TIMEOUT,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
)(
   input logic                clk,
   input logic                rst,
   flash_read_arbiter_if.slave bus
);

   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_next;
   logic [FW-1:0]     r_flush_cnt;
   logic [TW-1:0]     r_tmo_cnt;
   logic              r_owner;
   logic              r_last_grant;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic [1:0]        r_busy;
   logic [1:0]        r_valid;
   logic [1:0]        r_done;
   logic [1:0]        r_err;
   logic              r_fl_read;
   logic [ADDR_W-1:0] r_fl_addr;
   logic [7:0]        r_rd_data;

   logic [1:0]        w_grant;
   logic              w_gnt_id;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [LEN_W-1:0]  w_gnt_len;
   logic              w_acked;
   logic              w_flush_done;
   logic              w_timeout;

   flash_arb_rr2 u_rr2 (
      .i_req        ({bus.b_req, bus.a_req}),
      .i_last_grant (r_last_grant),
      .i_enable     (r_state == ST_IDLE),
      .o_grant      (w_grant)
   );

   assign w_gnt_id     = w_grant[REQ_B];
   assign w_gnt_addr   = w_gnt_id ? bus.b_addr : bus.a_addr;
   assign w_gnt_len    = w_gnt_id ? bus.b_len  : bus.a_len;
   // An ack only counts while the owner's byte is actually presented.
   assign w_acked      = (r_owner ? bus.b_ack : bus.a_ack) & r_valid[r_owner];
   assign w_flush_done = (r_flush_cnt == FW'(FLUSH_CYCLES - 1));
   assign w_timeout    = (r_tmo_cnt == TW'(TIMEOUT - 1));

   // State register; reset re-enters FLUSH to soak up a reader that kept running.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FLUSH;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FLUSH:   if (w_flush_done) w_next = ST_IDLE;
         ST_IDLE:    if ((w_grant != 2'b00) && (w_gnt_len != '0)) w_next = ST_ISSUE;
         ST_ISSUE:   w_next = ST_WAIT;
         ST_WAIT: begin
            if (bus.fl_ready)   w_next = ST_DELIVER;
            else if (w_timeout) w_next = ST_IDLE;
         end
         ST_DELIVER: begin
            if (w_acked) w_next = (r_remaining == LEN_W'(1)) ? ST_IDLE : ST_ISSUE;
         end
         default:    w_next = ST_FLUSH;
      endcase
   end

   // Burst bookkeeping and registered outputs; fl_read is raised on the edge
   // entering ISSUE so it is high for exactly the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_cnt  <= '0;
         r_tmo_cnt    <= '0;
         r_owner      <= REQ_A;
         r_last_grant <= REQ_B;
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_busy       <= '0;
         r_valid      <= '0;
         r_done       <= '0;
         r_err        <= '0;
         r_fl_read    <= 1'b0;
         r_fl_addr    <= '0;
         r_rd_data    <= '0;
      end else begin
         r_done    <= '0;
         r_err     <= '0;
         r_fl_read <= 1'b0;
         case (r_state)
            ST_FLUSH: r_flush_cnt <= r_flush_cnt + 1'b1;
            ST_IDLE: begin
               if (w_grant != 2'b00) begin
                  r_owner      <= w_gnt_id;
                  r_last_grant <= w_gnt_id;
                  r_cur_addr   <= w_gnt_addr;
                  r_remaining  <= w_gnt_len;
                  if (w_gnt_len == '0) begin
                     r_done[w_gnt_id] <= 1'b1;
                  end else begin
                     r_busy[w_gnt_id] <= 1'b1;
                     r_fl_read        <= 1'b1;
                     r_fl_addr        <= w_gnt_addr;
                  end
               end
            end
            ST_ISSUE: r_tmo_cnt <= '0;
            ST_WAIT: begin
               if (bus.fl_ready) begin
                  r_rd_data        <= bus.fl_data;
                  r_valid[r_owner] <= 1'b1;
               end else if (w_timeout) begin
                  r_err[r_owner]  <= 1'b1;
                  r_done[r_owner] <= 1'b1;
                  r_busy[r_owner] <= 1'b0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            ST_DELIVER: begin
               if (w_acked) begin
                  r_valid[r_owner] <= 1'b0;
                  r_cur_addr       <= r_cur_addr + 1'b1;
                  r_remaining      <= r_remaining - 1'b1;
                  if (r_remaining == LEN_W'(1)) begin
                     r_done[r_owner] <= 1'b1;
                     r_busy[r_owner] <= 1'b0;
                  end else begin
                     r_fl_read <= 1'b1;
                     r_fl_addr <= r_cur_addr + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.a_busy  = r_busy[REQ_A];
   assign bus.a_valid = r_valid[REQ_A];
   assign bus.a_done  = r_done[REQ_A];
   assign bus.a_err   = r_err[REQ_A];
   assign bus.b_busy  = r_busy[REQ_B];
   assign bus.b_valid = r_valid[REQ_B];
   assign bus.b_done  = r_done[REQ_B];
   assign bus.b_err   = r_err[REQ_B];
   assign bus.rd_data = r_rd_data;
   assign bus.fl_read = r_fl_read;
   assign bus.fl_addr = r_fl_addr;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: stimulus pushes expected reader
// addresses, bytes and done/err events into queues; a negedge monitor pops
// and compares whenever the DUT presents them.
module tb_flash_read_arbiter;
   import flash_arb_pkg::*;

   localparam int LEN_W        = 8;
   localparam int TIMEOUT      = DEF_TIMEOUT;
   localparam int FLUSH_CYCLES = DEF_FLUSH_CYCLES;
   localparam int RD_LAT       = 3;

   typedef struct packed { logic port; logic [7:0] data; } byte_t;
   typedef struct packed { logic port; logic err; } done_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_read_cyc = 0;
   int   stray_cnt = 0;
   bit   reader_en = 1'b1;
   bit   ack_en = 1'b1;

   logic [23:0] exp_addr_q[$];
   byte_t       exp_byte_q[$];
   done_t       exp_done_q[$];
   logic [7:0]  rd_bytes_q[$];

   flash_read_arbiter_if #(.LEN_W(LEN_W)) bus ();

   flash_read_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   function automatic logic [9:0] outs();
      return {bus.a_busy, bus.a_valid, bus.a_done, bus.a_err,
              bus.b_busy, bus.b_valid, bus.b_done, bus.b_err, bus.fl_read, 1'b0};
   endfunction

   // Monitor / scoreboard
   initial begin : monitor
      logic       pa;
      logic       pb;
      logic [7:0] held;
      byte_t      eb;
      done_t      ed;
      pa = 1'b0; pb = 1'b0; held = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            pa = 1'b0; pb = 1'b0;
         end else begin
            if (bus.fl_read) begin
               last_read_cyc = cyc;
               if (exp_addr_q.size() == 0) flag("unexpected_fl_read", 32'(bus.fl_addr), 0);
               else check_eq("fl_addr", 32'(bus.fl_addr), 32'(exp_addr_q.pop_front()));
            end
            if ((bus.a_valid && !pa) || (bus.b_valid && !pb)) begin
               if (exp_byte_q.size() == 0) flag("unexpected_valid", {bus.a_valid, bus.b_valid}, 0);
               else begin
                  eb = exp_byte_q.pop_front();
                  check_eq("valid_port", 32'(bus.b_valid), 32'(eb.port));
                  check_eq("rd_data", 32'(bus.rd_data), 32'(eb.data));
               end
               held = bus.rd_data;
            end else if ((bus.a_valid || bus.b_valid) && bus.rd_data != held) begin
               flag("rd_data_stable", 32'(bus.rd_data), 32'(held));
            end
            if (bus.a_valid && bus.b_valid) flag("valid_exclusive", 2'b11, 2'b01);
            if (bus.a_busy && bus.b_busy)   flag("busy_exclusive", 2'b11, 2'b01);
            if ((bus.a_valid && !bus.a_busy) || (bus.b_valid && !bus.b_busy))
               flag("valid_without_busy", {bus.a_valid, bus.b_valid}, 0);
            if ((bus.a_err && !bus.a_done) || (bus.b_err && !bus.b_done))
               flag("err_without_done", {bus.a_err, bus.b_err}, 0);
            if (bus.a_done || bus.b_done) begin
               if (bus.a_done && bus.b_done) flag("done_exclusive", 2'b11, 2'b01);
               else if (exp_done_q.size() == 0) flag("unexpected_done", {bus.a_done, bus.b_done}, 0);
               else begin
                  ed = exp_done_q.pop_front();
                  check_eq("done_port", 32'(bus.b_done), 32'(ed.port));
                  check_eq("done_err", 32'(bus.b_done ? bus.b_err : bus.a_err), 32'(ed.err));
                  if (ed.err) check_range("timeout_latency", cyc - last_read_cyc, TIMEOUT, TIMEOUT + 2);
               end
            end
            pa = bus.a_valid;
            pb = bus.b_valid;
         end
      end
   end

   // Flash reader model: answers each strobe after RD_LAT cycles, or emits a stray pulse on request.
   initial begin : reader
      int seen;
      seen = 0;
      bus.fl_ready = 1'b0;
      bus.fl_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (stray_cnt != seen) begin
            seen = stray_cnt;
            bus.fl_ready = 1'b1;
            bus.fl_data  = 8'h5A;
            @(negedge clk);
            bus.fl_ready = 1'b0;
         end else if (bus.fl_read && reader_en && !rst) begin
            repeat (RD_LAT) @(negedge clk);
            bus.fl_ready = 1'b1;
            bus.fl_data  = (rd_bytes_q.size() != 0) ? rd_bytes_q.pop_front() : 8'hEE;
            @(negedge clk);
            bus.fl_ready = 1'b0;
         end
      end
   end

   // Client ack model: zero-wait ack while enabled.
   initial begin : acker
      bus.a_ack = 1'b0;
      bus.b_ack = 1'b0;
      forever begin
         @(negedge clk);
         bus.a_ack = ack_en && bus.a_valid;
         bus.b_ack = ack_en && bus.b_valid;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic req_one(input logic port, input logic [23:0] addr, input logic [LEN_W-1:0] len);
      bit granted;
      granted = 1'b0;
      if (port == REQ_A) begin bus.a_addr = addr; bus.a_len = len; bus.a_req = 1'b1; end
      else               begin bus.b_addr = addr; bus.b_len = len; bus.b_req = 1'b1; end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (port == REQ_A ? (bus.a_busy || bus.a_done) : (bus.b_busy || bus.b_done)) begin
            granted = 1'b1;
            break;
         end
      end
      if (!granted) flag("grant_timeout", 0, 1);
      if (port == REQ_A) bus.a_req = 1'b0;
      else               bus.b_req = 1'b0;
   endtask

   task automatic req_both(input logic [23:0] aa, input logic [23:0] ba);
      bus.a_addr = aa; bus.a_len = 8'd1; bus.a_req = 1'b1;
      bus.b_addr = ba; bus.b_len = 8'd1; bus.b_req = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.a_busy || bus.a_done) bus.a_req = 1'b0;
         if (bus.b_busy || bus.b_done) bus.b_req = 1'b0;
         if (!bus.a_req && !bus.b_req) break;
      end
      if (bus.a_req || bus.b_req) flag("both_grant_timeout", {bus.a_req, bus.b_req}, 0);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   task automatic drain(input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (exp_addr_q.size() == 0 && exp_byte_q.size() == 0 && exp_done_q.size() == 0 &&
             !bus.a_busy && !bus.b_busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) flag("drain_timeout", exp_addr_q.size() + exp_byte_q.size() + exp_done_q.size(), 0);
   endtask

   initial begin : stim
      int nreads, nlow, nchg, rel;
      bit seen_busy;
      rst = 1'b1;
      bus.a_req = 1'b0; bus.a_addr = '0; bus.a_len = '0;
      bus.b_req = 1'b0; bus.b_addr = '0; bus.b_len = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_outputs", 32'(outs()), 0);
      check_eq("rst_fl_addr", 32'(bus.fl_addr), 0);
      check_eq("rst_rd_data", 32'(bus.rd_data), 0);
      rst = 1'b0;
      repeat (FLUSH_CYCLES + 2) @(negedge clk);

      // A alone, three bytes
      rd_bytes_q = '{8'h11, 8'h22, 8'h33};
      exp_addr_q = '{24'h400000, 24'h400001, 24'h400002};
      exp_byte_q = '{'{1'b0, 8'h11}, '{1'b0, 8'h22}, '{1'b0, 8'h33}};
      exp_done_q = '{'{1'b0, 1'b0}};
      req_one(REQ_A, 24'h400000, 8'd3);
      drain(300);

      // B wraps the 24-bit address
      rd_bytes_q = '{8'h01, 8'h02, 8'h03};
      exp_addr_q = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
      exp_byte_q = '{'{1'b1, 8'h01}, '{1'b1, 8'h02}, '{1'b1, 8'h03}};
      exp_done_q = '{'{1'b1, 1'b0}};
      req_one(REQ_B, 24'hFFFFFE, 8'd3);
      drain(300);

      // Tie after a B grant: A first, then B
      rd_bytes_q = '{8'hA5, 8'hB5};
      exp_addr_q = '{24'h000100, 24'h000200};
      exp_byte_q = '{'{1'b0, 8'hA5}, '{1'b1, 8'hB5}};
      exp_done_q = '{'{1'b0, 1'b0}, '{1'b1, 1'b0}};
      req_both(24'h000100, 24'h000200);
      drain(300);

      // A with ack withheld for 100 cycles
      ack_en = 1'b0;
      rd_bytes_q = '{8'hC1, 8'hC2};
      exp_addr_q = '{24'h123456, 24'h123457};
      exp_byte_q = '{'{1'b0, 8'hC1}, '{1'b0, 8'hC2}};
      exp_done_q = '{'{1'b0, 1'b0}};
      req_one(REQ_A, 24'h123456, 8'd2);
      for (int i = 0; i < 50 && !bus.a_valid; i++) @(negedge clk);
      nreads = 0; nlow = 0; nchg = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.fl_read) nreads++;
         if (!bus.a_valid) nlow++;
         if (bus.rd_data != 8'hC1) nchg++;
      end
      check_eq("hold_no_fl_read", nreads, 0);
      check_eq("hold_valid_low_cycles", nlow, 0);
      check_eq("hold_data_changes", nchg, 0);
      ack_en = 1'b1;
      drain(300);

      // Tie after an A grant: B first, then A
      rd_bytes_q = '{8'h4B, 8'h3A};
      exp_addr_q = '{24'h000400, 24'h000300};
      exp_byte_q = '{'{1'b1, 8'h4B}, '{1'b0, 8'h3A}};
      exp_done_q = '{'{1'b1, 1'b0}, '{1'b0, 1'b0}};
      req_both(24'h000300, 24'h000400);
      drain(300);

      // Reader never answers: timeout abort on A
      reader_en = 1'b0;
      exp_addr_q = '{24'h00ABCD};
      exp_done_q = '{'{1'b0, 1'b1}};
      req_one(REQ_A, 24'h00ABCD, 8'd1);
      drain(600);
      reader_en = 1'b1;

      // B served normally afterwards
      rd_bytes_q = '{8'h77};
      exp_addr_q = '{24'h000010};
      exp_byte_q = '{'{1'b1, 8'h77}};
      exp_done_q = '{'{1'b1, 1'b0}};
      req_one(REQ_B, 24'h000010, 8'd1);
      drain(300);

      // Zero-length burst: done only, no reader access
      exp_done_q = '{'{1'b0, 1'b0}};
      req_one(REQ_A, 24'h555555, 8'd0);
      drain(50);

      // Reset while waiting on the reader
      reader_en = 1'b0;
      exp_addr_q = '{24'h00F000};
      req_one(REQ_A, 24'h00F000, 8'd2);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_outputs", 32'(outs()), 0);
      rst = 1'b0;
      rel = cyc;
      reader_en = 1'b1;
      rd_bytes_q = '{8'h61, 8'h62};
      exp_addr_q = '{24'h0A0000, 24'h0A0001};
      exp_byte_q = '{'{1'b0, 8'h61}, '{1'b0, 8'h62}};
      exp_done_q = '{'{1'b0, 1'b0}};
      bus.a_addr = 24'h0A0000; bus.a_len = 8'd2; bus.a_req = 1'b1;
      seen_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 20) stray_cnt++;
         if (bus.a_busy) begin seen_busy = 1'b1; break; end
      end
      bus.a_req = 1'b0;
      check_eq("post_rst_grant_seen", 32'(seen_busy), 1);
      check_range("flush_quiet_cycles", cyc - rel, FLUSH_CYCLES, FLUSH_CYCLES + 4);
      drain(300);

      check_eq("leftover_expectations", exp_addr_q.size() + exp_byte_q.size() + exp_done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares one dspi_flash_reader between two requesters, A and B.
- Each requester asks for a burst of N bytes from a 24-bit start address.
- The arbiter grants one requester at a time using round-robin. It issues one single-byte flash read per byte, increments the address, and returns each byte with a valid/ack handshake.
- Sits between the flash reader and client logic, for example a UART dump engine and a loader.

Parameters:
- LEN_W, 8: width of the burst length field; max burst 2^LEN_W-1 bytes.
- TIMEOUT, 255: max cycles from fl_read to fl_ready before the read is aborted.
- FLUSH_CYCLES, 64: post-reset quiet period; must exceed one full reader transaction (44 cycles).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A burst request; level, sampled only in IDLE.
- a_addr  in  24  requester A start address; captured at grant.
- a_len  in  LEN_W  requester A byte count; captured at grant.
- a_busy  out  1  A owns the flash.
- a_valid  out  1  byte for A available on rd_data.
- a_ack  in  1  A consumes the byte.
- a_done  out  1  one-cycle pulse: A burst finished.
- a_err  out  1  one-cycle pulse, coincident with a_done: A burst aborted by timeout.
- b_req, b_addr, b_len, b_busy, b_valid, b_ack, b_done, b_err: same for B.
- rd_data  out  8  returned byte; shared by both requesters, qualified by x_valid.
- fl_read  out  1  read strobe to the reader.
- fl_addr  out  24  address to the reader.
- fl_ready  in  1  reader one-cycle completion pulse.
- fl_data  in  8  reader data, valid while fl_ready is high.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; fl_addr = 0; rd_data = 0; state FLUSH; flush counter 0; last_grant = B, so A wins the first tie.
- FLUSH state:
  - Ignore fl_ready and all requests for FLUSH_CYCLES cycles, then go to IDLE.
  - This absorbs an in-flight reader transaction, since the reader has no reset.
- IDLE state:
  - If only one x_req is high, grant that requester.
  - If both are high, grant the one not equal to last_grant.
  - On grant, capture addr and len into cur_addr/remaining, set x_busy = 1, and update last_grant.
  - If len == 0: pulse x_done next cycle, no flash access, drop busy in the same cycle, stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE state:
  - fl_read = 1 for exactly one cycle; fl_addr = cur_addr.
  - The first fl_read occurs in the cycle after the grant cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT state:
  - On fl_ready: latch fl_data into rd_data and set x_valid = 1 the next cycle. Go to DELIVER.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: pulse x_err and x_done, drop x_busy, go to IDLE.
  - fl_ready outside WAIT is ignored.
- DELIVER state:
  - Hold x_valid and rd_data until x_ack is high while x_valid is high.
  - On that cycle: x_valid = 0, cur_addr = cur_addr+1 (mod 2^24, so 0xFFFFFF -> 0x000000), remaining = remaining-1.
  - If remaining was 1: pulse x_done, drop x_busy, go to IDLE.
  - Otherwise go to ISSUE.
  - x_ack without x_valid is ignored.
- Only the granted port's valid/done/err/busy ever assert; the other port's outputs stay 0.
- x_req changes during a burst have no effect. Requests are re-evaluated only in IDLE; a re-grant is possible in the cycle after done.
- rst mid-burst: outputs clear in the next cycle with no done or err pulse, and the block re-enters FLUSH.
- Throughput: one byte per reader latency (~44 cycles) + 3 cycles with zero-wait ack.

Decomposition:
- Package flash_arb_pkg:
  - state encoding (FLUSH, IDLE, ISSUE, WAIT, DELIVER);
  - requester ids (REQ_A = 0, REQ_B = 1);
  - ADDR_W = 24;
  - default TIMEOUT and FLUSH_CYCLES.
- Sub-module flash_arb_rr2:
  - 2-way round-robin grant;
  - inputs: req[1:0], last_grant, enable;
  - output: one-hot grant.

Test Plan:
- Reset, then after FLUSH only A requests addr=0x400000 len=3, ack immediate, reader model returns 0x11, 0x22, 0x33 → fl_addr sequence 0x400000, 0x400001, 0x400002; a_valid data 11, 22, 33; a_done one pulse after 3rd ack; b_* stay 0.
- A and B both request in the same IDLE cycle, len=1 each → A granted first, then B; a second simultaneous request → B first (alternation).
- B addr=0xFFFFFE len=3 → fl_addr 0xFFFFFE, 0xFFFFFF, 0x000000.
- A len=2 with ack held low 100 cycles → rd_data and a_valid stable throughout; no second fl_read until ack; bytes arrive in order.
- Reader model never asserts fl_ready → a_err and a_done pulse together TIMEOUT cycles after fl_read; the next B request is served normally. Also A len=0 → a_done with no fl_read.
- rst asserted during WAIT, with a stray fl_ready 20 cycles later → no valid/done; no fl_read for FLUSH_CYCLES; then a normal burst succeeds.
